cpu_boot_ctrl: RTL and testbench
================================

# cpu_boot_ctrl

Boot/run sequencer that sits directly upstream of `cpu` and drives its control inputs `pc_ld`, `pc_data` and `clockthing`, replacing the hand-timed stimulus in bench initial blocks.
- On `start` it loads the boot PC with a one-cycle `pc_ld` pulse, then waits a settle interval.
- It then enables execution (`clockthing`) until the CPU signals halt or a cycle budget expires.
- It reports `done`, `timeout` and the executed cycle count, so benches and system top levels get deterministic, cycle-exact bring-up.

## Interface
Parameters:
- `BOOT_PC`, 32'h0040_0020: value presented on `pc_data` during the load pulse.
- `SETTLE_CYCLES`, 2: cycles between the `pc_ld` pulse and run enable; 0 allowed.
- `MAX_RUN_CYCLES`, 160: run-cycle budget before forced stop; 0 = unlimited.

Ports:
- `clk`  in  1  system clock, rising edge. One clock domain; reset is asynchronous and active-low.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  level-sampled request to (re)boot; honoured only in IDLE or DONE.
- `halt`  in  1  CPU end-of-program indication; honoured only in RUN.
- `pc_ld`  out  1  PC load strobe to `cpu`.
- `pc_data`  out  32  PC load value to `cpu`.
- `clockthing`  out  1  CPU run enable.
- `busy`  out  1  high in LOAD, SETTLE and RUN.
- `done`  out  1  high in DONE.
- `timeout`  out  1  high in DONE when the run ended on the budget.
- `cycle_count`  out  32  number of RUN cycles executed.

## Operation
- FSM states: IDLE, LOAD, SETTLE, RUN, DONE. All outputs are registered (Moore outputs).
- IDLE:
  - All outputs 0.
  - `start`=1 at an edge -> LOAD.
- LOAD (exactly 1 cycle):
  - `pc_ld`=1, `pc_data`=BOOT_PC; `cycle_count`, `done` and `timeout` are cleared.
  - Next state: SETTLE, or RUN directly if SETTLE_CYCLES=0.
- SETTLE:
  - `pc_ld`=0, `pc_data`=0, `clockthing`=0.
  - The settle counter runs SETTLE_CYCLES cycles, then -> RUN.
- RUN:
  - `clockthing`=1.
  - `cycle_count` increments at every edge that leaves a RUN cycle, including the final one.
  - `halt`=1 at an edge -> DONE with `timeout`=0.
  - If MAX_RUN_CYCLES≠0 and the incremented count equals MAX_RUN_CYCLES -> DONE with `timeout`=1.
- DONE:
  - `clockthing`=0, `done`=1; `cycle_count` and `timeout` hold.
  - `start`=1 -> LOAD, which restarts the full sequence and clears the status.
- Ignored inputs:
  - `start` is ignored in LOAD, SETTLE and RUN.
  - `halt` is ignored outside RUN.
- Arithmetic:
  - `cycle_count` is 32-bit unsigned and saturates at 32'hFFFF_FFFF. Saturation can only occur when MAX_RUN_CYCLES=0.
  - The settle counter is sized to hold SETTLE_CYCLES.

## Timing
- Reset values: all outputs 0, state IDLE, internal counters 0.
- Reset is asynchronous: assertion of `rst_n` mid-operation forces IDLE and zeroes every output immediately, without waiting for a clock edge. Deassertion is taken at the next rising edge.
- Start latency:
  - `start` sampled at edge E0 -> `pc_ld`=1 during cycle E0..E1.
  - `clockthing` rises at edge E1+SETTLE_CYCLES.
- `pc_ld` is high for exactly one cycle per boot. `pc_data` is nonzero only while `pc_ld`=1.
- Run length:
  - `clockthing` stays high for exactly N cycles, where N = final `cycle_count`.
  - N = MAX_RUN_CYCLES on timeout.
  - On halt, N = index of the RUN cycle, counting from 1, in which `halt` was sampled.
- Simultaneous halt and budget expiry in the same cycle: halt wins, `timeout`=0, count = MAX_RUN_CYCLES.
- `halt` in the first RUN cycle gives count 1.
- `done` rises on the same edge that `clockthing` falls.
- `start` held continuously re-boots on the edge after DONE is entered, so DONE lasts exactly one cycle.

## Test plan
- Nominal boot: defaults, `start` pulsed for 1 cycle, `halt`=0 throughout ->
  - one `pc_ld` pulse with `pc_data`=32'h0040_0020;
  - `clockthing` high 2 cycles later, for 160 cycles;
  - then `done`=1, `timeout`=1, `cycle_count`=160.
- Halt stop: `halt` asserted in RUN cycle 37 ->
  - `clockthing` falls at the next edge;
  - `done`=1, `timeout`=0, `cycle_count`=37.
- Zero settle and simultaneous events: SETTLE_CYCLES=0, MAX_RUN_CYCLES=5, `halt` asserted in RUN cycle 5 ->
  - `clockthing` rises the cycle after `pc_ld`;
  - `timeout`=0, `cycle_count`=5.
- Ignored inputs: `start` re-pulsed during SETTLE and RUN, `halt` pulsed in IDLE and SETTLE -> no extra `pc_ld`, no state change.
- Restart: `start` in DONE -> `done`, `timeout` and `cycle_count` cleared on the LOAD cycle; full sequence repeats with identical timing.
- Reset mid-run: `rst_n` low for 3 ns during RUN, between clock edges ->
  - `clockthing`, `busy` and `cycle_count` go to 0 immediately;
  - FSM stays in IDLE until the next `start`.

Source files
------------

// File: rtl/cpu_boot_ctrl.sv
// Boot/run sequencer for the cpu: pulses a PC load, waits a settle interval,
// then enables execution until halt or the run-cycle budget expires.
module cpu_boot_ctrl #(
  parameter logic [31:0] BOOT_PC        = 32'h0040_0020,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned MAX_RUN_CYCLES = 160
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt,
  output logic        pc_ld,
  output logic [31:0] pc_data,
  output logic        clockthing,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] cycle_count
);

  localparam int SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SET_LAST = SW'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
  localparam logic [31:0]   RUN_MAX  = MAX_RUN_CYCLES;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] settle_cnt, settle_nxt;
  logic [31:0]   count_nxt, count_inc;
  logic          timeout_nxt;

  assign count_inc = (cycle_count == '1) ? cycle_count : cycle_count + 32'd1;

  always_comb begin
    state_nxt   = state;
    settle_nxt  = settle_cnt;
    count_nxt   = cycle_count;
    timeout_nxt = timeout;
    case (state)
      S_IDLE, S_DONE: begin
        // status is cleared on entry so it already reads 0 during LOAD
        if (start) begin
          state_nxt   = S_LOAD;
          count_nxt   = '0;
          timeout_nxt = 1'b0;
        end
      end
      S_LOAD: begin
        settle_nxt = '0;
        state_nxt  = (SETTLE_CYCLES == 0) ? S_RUN : S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_cnt == SET_LAST) begin
          settle_nxt = '0;
          state_nxt  = S_RUN;
        end else begin
          settle_nxt = settle_cnt + 1'b1;
        end
      end
      S_RUN: begin
        count_nxt = count_inc;
        // halt takes priority over a budget expiring on the same edge
        if (halt) begin
          state_nxt   = S_DONE;
          timeout_nxt = 1'b0;
        end else if (MAX_RUN_CYCLES != 0 && count_inc == RUN_MAX) begin
          state_nxt   = S_DONE;
          timeout_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      settle_cnt  <= '0;
      pc_ld       <= 1'b0;
      pc_data     <= '0;
      clockthing  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      state       <= state_nxt;
      settle_cnt  <= settle_nxt;
      pc_ld       <= (state_nxt == S_LOAD);
      pc_data     <= (state_nxt == S_LOAD) ? BOOT_PC : '0;
      clockthing  <= (state_nxt == S_RUN);
      busy        <= (state_nxt == S_LOAD) || (state_nxt == S_SETTLE) || (state_nxt == S_RUN);
      done        <= (state_nxt == S_DONE);
      timeout     <= timeout_nxt;
      cycle_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Bench for cpu_boot_ctrl: two instances (default and zero-settle/5-cycle budget)
// checked every cycle against a boot-timeline model, plus directed table and reset sequences.
module tb_cpu_boot_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] start_v, halt_v, pc_ld_o, clk_o, busy_o, done_o, to_o;
  logic [1:0][31:0] pc_data_o, count_o;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cpu_boot_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .halt(halt_v[0]),
    .pc_ld(pc_ld_o[0]), .pc_data(pc_data_o[0]), .clockthing(clk_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .timeout(to_o[0]), .cycle_count(count_o[0])
  );

  cpu_boot_ctrl #(.SETTLE_CYCLES(0), .MAX_RUN_CYCLES(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .halt(halt_v[1]),
    .pc_ld(pc_ld_o[1]), .pc_data(pc_data_o[1]), .clockthing(clk_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .timeout(to_o[1]), .cycle_count(count_o[1])
  );

  typedef struct {
    int sel;
    int k;       // RUN cycle (from 1) in which halt is raised; out of range = never
    int dlen;    // DONE cycles before the next start
    int exp_n;
    bit exp_to;
  } vec_t;

  function automatic logic [68:0] got(int sel);
    return {pc_ld_o[sel], pc_data_o[sel], clk_o[sel], busy_o[sel], done_o[sel], to_o[sel], count_o[sel]};
  endfunction

  task automatic check(string name, int sel, logic [68:0] exp);
    total++;
    if (got(sel) !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %h want %h", name, sel, got(sel), exp);
    end
  endtask

  // One boot from IDLE/DONE; expected outputs come from the boot timeline:
  // LOAD at c=0, settle for S cycles, RUN for N cycles, then DONE.
  task automatic episode(input int sel, input int k, input int dlen, input int exp_n, input bit exp_to);
    int s, m, n;
    bit to, ld, rn, dn;
    logic [31:0] cnt;
    logic [68:0] e;
    s = (sel == 0) ? 2 : 0;
    m = (sel == 0) ? 160 : 5;
    to = !(k >= 1 && k <= m);
    n = to ? m : k;
    start_v = '0;
    halt_v = '0;
    start_v[sel] = 1'b1;
    halt_v[sel] = 1'($urandom_range(0, 1));
    for (int c = 0; c < 1 + s + n + dlen; c++) begin
      @(negedge clk);
      ld = (c == 0);
      rn = (c >= 1 + s) && (c < 1 + s + n);
      dn = (c >= 1 + s + n);
      cnt = (c <= s) ? 32'd0 : (rn ? 32'(c - s - 1) : 32'(n));
      e = {ld, ld ? 32'h0040_0020 : 32'h0, rn, !dn, dn, dn && to, cnt};
      check("timeline", sel, e);
      start_v[sel] = dn ? 1'b0 : 1'($urandom_range(0, 1));
      halt_v[sel] = rn ? (c - s == k) : 1'($urandom_range(0, 1));
    end
    halt_v[sel] = 1'b0;
    total++;
    if (count_o[sel] !== 32'(exp_n) || to_o[sel] !== exp_to || done_o[sel] !== 1'b1) begin
      bad++;
      $display("FAIL final dut%0d k=%0d: got n=%0d to=%0d done=%0d want n=%0d to=%0d",
               sel, k, count_o[sel], to_o[sel], done_o[sel], exp_n, exp_to);
    end
  endtask

  initial begin
    vec_t tbl[8];
    tbl[0] = '{0, 0,   1, 160, 1'b1};  // nominal timeout, immediate restart
    tbl[1] = '{0, 37,  2, 37,  1'b0};  // halt in RUN cycle 37
    tbl[2] = '{1, 5,   1, 5,   1'b0};  // halt and budget together: halt wins
    tbl[3] = '{1, 0,   2, 5,   1'b1};
    tbl[4] = '{1, 1,   1, 1,   1'b0};  // halt in first RUN cycle
    tbl[5] = '{1, 6,   1, 5,   1'b1};
    tbl[6] = '{0, 1,   2, 1,   1'b0};
    tbl[7] = '{0, 160, 2, 160, 1'b0};

    rst_n = 1'b0;
    start_v = '0;
    halt_v = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // halt pulses in IDLE must not disturb anything
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("reset_idle", 0, '0);
      check("reset_idle", 1, '0);
      halt_v = 2'($urandom_range(0, 3));
    end
    halt_v = '0;

    foreach (tbl[i]) episode(tbl[i].sel, tbl[i].k, tbl[i].dlen, tbl[i].exp_n, tbl[i].exp_to);

    for (int i = 0; i < 16; i++) begin
      int sel, m, k, n;
      sel = $urandom_range(0, 1);
      m = (sel == 0) ? 160 : 5;
      k = $urandom_range(0, m + 2);
      n = (k >= 1 && k <= m) ? k : m;
      episode(sel, k, $urandom_range(1, 3), n, !(k >= 1 && k <= m));
    end

    // asynchronous reset in the middle of a run
    start_v = '0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (12) @(negedge clk);
    check("pre_reset_run", 0, {1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd9});
    #1 rst_n = 1'b0;
    #1;
    check("async_reset", 0, '0);
    check("async_reset", 1, '0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_reset_idle", 0, '0);
      check("post_reset_idle", 1, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
